fb_text_writer: RTL and testbench



---
 rtl/fb_text_writer.sv | 205 ++++++++++++++++++++
 tb/tb_fb_text_writer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_text_writer.sv
// rtl/fb_text_writer.sv - character/clear command front end for the VGA frame-buffer write port
// Optional feature macro: FB_WR_INVERT_EN (adds cmd_invert, reverse-video glyphs)
module fb_text_writer #(
    parameter int COLS     = 80,
    parameter int ROWS     = 60,
    parameter int FB_WORDS = 9600,
    parameter int ADDR_W   = 14
) (
    input  logic              CLK_25,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_clear,
    input  logic [6:0]        cmd_char,
    input  logic [6:0]        cmd_col,
    input  logic [5:0]        cmd_row,
    input  logic [31:0]       cmd_fill,
`ifdef FB_WR_INVERT_EN
    input  logic              cmd_invert,
`endif
    output logic [9:0]        font_addr,
    input  logic [7:0]        font_data,
    output logic [31:0]       WrData,
    output logic [ADDR_W-1:0] WrAddress,
    output logic              WrEn,
    output logic              err_range
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam logic [6:0]        COLS_L    = 7'(COLS);
    localparam logic [5:0]        ROWS_L    = 6'(ROWS);
    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(2 * COLS);
    localparam logic [ADDR_W-1:0] HALF_OFS  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [6:0]          char_q, char_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [23:0]         pack_q, pack_d;
    logic [9:0]          font_addr_q, font_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                wr_en_q, wr_en_d;
    logic                err_q, err_d;
    logic [7:0]          glyph_byte;
    logic [ADDR_W-1:0]   top_addr;
    logic                in_range;
    logic [1:0]          byte_idx;

    // Font bit 7 is the leftmost pixel, but the frame buffer puts the leftmost pixel in bit 0.
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

`ifdef FB_WR_INVERT_EN
    logic inv_q, inv_d;

    // Reverse-video flag, captured with the rest of the command.
    always_ff @(posedge CLK_25 or posedge Reset) begin
        if (Reset) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end

    // Mirror the glyph row and optionally invert it for reverse video.
    always_comb begin
        inv_d      = inv_q;
        glyph_byte = rev8(font_data) ^ {8{inv_q}};
        if (state_q == S_IDLE && cmd_valid && !cmd_clear) begin
            inv_d = cmd_invert;
        end
    end
`else
    // Mirror the glyph row into frame-buffer pixel order.
    always_comb begin
        glyph_byte = rev8(font_data);
    end
`endif

    // Command decode helpers: top-half word address and legality of a draw.
    always_comb begin
        top_addr = {{(ADDR_W-6){1'b0}}, cmd_row} * ROW_PITCH + {{(ADDR_W-7){1'b0}}, cmd_col};
        in_range = (cmd_col < COLS_L) && (cmd_row < ROWS_L);
        byte_idx = 2'(cnt_q - 4'd1);
    end

    // All sequential state, reset asynchronously so a mid-operation reset drops WrEn at once.
    always_ff @(posedge CLK_25 or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            char_q      <= 7'd0;
            base_q      <= '0;
            pack_q      <= 24'd0;
            font_addr_q <= 10'd0;
            wr_data_q   <= 32'd0;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            char_q      <= char_d;
            base_q      <= base_d;
            pack_q      <= pack_d;
            font_addr_q <= font_addr_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            wr_en_q     <= wr_en_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: accept in IDLE, walk the 8 glyph rows in FETCH, sweep the buffer in CLEAR.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        char_d      = char_q;
        base_d      = base_q;
        pack_d      = pack_q;
        font_addr_d = font_addr_q;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_addr_q;
        wr_en_d     = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_clear) begin
                        state_d   = S_CLEAR;
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        wr_data_d = cmd_fill;
                    end else if (in_range) begin
                        state_d     = S_FETCH;
                        cnt_d       = 4'd0;
                        char_d      = cmd_char;
                        base_d      = top_addr;
                        font_addr_d = {cmd_char, 3'd0};
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_FETCH: begin
                cnt_d = cnt_q + 4'd1;
                // cnt_q counts cycles since accept minus one; row cnt_q+1 is addressed next.
                if (cnt_q < 4'd7) begin
                    font_addr_d = {char_q, 3'(cnt_q + 4'd1)};
                end
                // font_data in this cycle belongs to row cnt_q-1.
                if (cnt_q >= 4'd1 && cnt_q <= 4'd8) begin
                    if (byte_idx == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {glyph_byte, pack_q};
                        wr_addr_d = (cnt_q == 4'd4) ? base_q : base_q + HALF_OFS;
                    end else begin
                        pack_d[{byte_idx, 3'b000} +: 8] = glyph_byte;
                    end
                end
                if (cnt_q == 4'd9) begin
                    state_d = S_IDLE;
                end
            end

            S_CLEAR: begin
                if (wr_addr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers; ready is simply "idle".
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        font_addr = font_addr_q;
        WrData    = wr_data_q;
        WrAddress = wr_addr_q;
        WrEn      = wr_en_q;
        err_range = err_q;
    end

endmodule

// File: tb/tb_fb_text_writer.sv
// tb/tb_fb_text_writer.sv - self-checking bench for fb_text_writer
module tb_fb_text_writer;

    localparam int ADDR_W = 14;

    logic              CLK_25 = 1'b0;
    logic              Reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_clear;
    logic [6:0]        cmd_char;
    logic [6:0]        cmd_col;
    logic [5:0]        cmd_row;
    logic [31:0]       cmd_fill;
    logic              cmd_invert;
    logic [9:0]        font_addr;
    logic [7:0]        font_data;
    logic [31:0]       WrData;
    logic [ADDR_W-1:0] WrAddress;
    logic              WrEn;
    logic              err_range;

    logic [7:0] rom [0:1023];

    int checks   = 0;
    int failures = 0;

    fb_text_writer dut (
        .CLK_25    (CLK_25),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_clear (cmd_clear),
        .cmd_char  (cmd_char),
        .cmd_col   (cmd_col),
        .cmd_row   (cmd_row),
        .cmd_fill  (cmd_fill),
`ifdef FB_WR_INVERT_EN
        .cmd_invert(cmd_invert),
`endif
        .font_addr (font_addr),
        .font_data (font_data),
        .WrData    (WrData),
        .WrAddress (WrAddress),
        .WrEn      (WrEn),
        .err_range (err_range)
    );

    always #20 CLK_25 = ~CLK_25;

    // Synchronous font ROM: data appears one cycle after the address.
    always @(posedge CLK_25) font_data <= rom[font_addr];

    function automatic logic [7:0] mirror(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Expected frame-buffer word for glyph rows half*4 .. half*4+3 of character ch.
    function automatic logic [31:0] glyph_word(input int ch, input int half, input logic inv);
        logic [31:0] w;
        for (int r = 0; r < 4; r++) w[8*r +: 8] = mirror(rom[ch*8 + half*4 + r]);
        return inv ? ~w : w;
    endfunction

    // Present a command and wait (bounded) for the accepting edge; returns just after it.
    task automatic issue(input logic clr, input logic [6:0] ch, input logic [6:0] col,
                         input logic [5:0] row, input logic [31:0] fill, input logic inv);
        int n;
        cmd_clear  = clr;
        cmd_char   = ch;
        cmd_col    = col;
        cmd_row    = row;
        cmd_fill   = fill;
        cmd_invert = inv;
        cmd_valid  = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20000) begin
            @(negedge CLK_25);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge CLK_25);
        #1;
    endtask

    // Draw a legal character and check every cycle T+1..T+11 against the model.
    task automatic check_draw(input int ch, input int col, input int row, input logic inv);
        int top;
        logic exp_we;
        logic [31:0] exp_data;
        int exp_addr;
        top = row*160 + col;
        issue(1'b0, 7'(ch), 7'(col), 6'(row), 32'h0, inv);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge CLK_25);
            if (k <= 8) begin
                checks++;
                if (font_addr !== 10'(ch*8 + k - 1)) begin
                    failures++;
                    $display("FAIL draw_font_addr k=%0d: got %h required %h", k, font_addr, 10'(ch*8 + k - 1));
                end
            end
            exp_we = (k == 6) || (k == 10);
            checks++;
            if (WrEn !== exp_we) begin
                failures++;
                $display("FAIL draw_wren k=%0d: got %b required %b", k, WrEn, exp_we);
            end
            if (exp_we) begin
                exp_addr = (k == 6) ? top : top + 80;
                exp_data = glyph_word(ch, (k == 6) ? 0 : 1, inv);
                checks++;
                if (WrAddress !== ADDR_W'(exp_addr) || WrData !== exp_data) begin
                    failures++;
                    $display("FAIL draw_write k=%0d: got addr=%0d data=%h required addr=%0d data=%h",
                             k, WrAddress, WrData, exp_addr, exp_data);
                end
            end
            checks++;
            if (cmd_ready !== (k == 11)) begin
                failures++;
                $display("FAIL draw_ready k=%0d: got %b required %b", k, cmd_ready, (k == 11));
            end
        end
    endtask

    task automatic test_reset;
        Reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_clear  = 1'b0;
        cmd_char   = 7'd0;
        cmd_col    = 7'd0;
        cmd_row    = 6'd0;
        cmd_fill   = 32'd0;
        cmd_invert = 1'b0;
        repeat (3) @(negedge CLK_25);
        checks++;
        if ({cmd_ready, WrEn, WrData, WrAddress, font_addr, err_range} !==
            {1'b1, 1'b0, 32'd0, 14'd0, 10'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: ready=%b we=%b data=%h addr=%0d fa=%h err=%b required 1 0 0 0 0 0",
                     cmd_ready, WrEn, WrData, WrAddress, font_addr, err_range);
        end
        Reset = 1'b0;
        @(negedge CLK_25);
    endtask

    task automatic test_h_glyph;
        logic [7:0] h [0:7];
        h = '{8'h00, 8'hCC, 8'hCC, 8'hFC, 8'hCC, 8'hCC, 8'hCC, 8'h00};
        for (int i = 0; i < 8; i++) rom[8'h48*8 + i] = h[i];
        check_draw(8'h48, 1, 0, 1'b0);
        checks++;
        if (glyph_word(8'h48, 1, 1'b0) !== 32'h00333333) begin
            failures++;
            $display("FAIL h_bottom_model: got %h required 00333333", glyph_word(8'h48, 1, 1'b0));
        end
    endtask

    task automatic test_corners;
        check_draw(int'($urandom_range(127, 0)), 79, 59, 1'b0);
        check_draw(int'($urandom_range(127, 0)), 0, 0, 1'b0);
        check_draw(int'($urandom_range(127, 0)), 79, 0, 1'b0);
        check_draw(int'($urandom_range(127, 0)), 0, 59, 1'b0);
    endtask

    task automatic test_random_draws;
        for (int i = 0; i < 10; i++) begin
            check_draw(int'($urandom_range(127, 0)), int'($urandom_range(79, 0)),
                       int'($urandom_range(59, 0)), 1'b0);
        end
    endtask

    task automatic test_back_to_back;
        check_draw(int'($urandom_range(127, 0)), int'($urandom_range(79, 0)), int'($urandom_range(59, 0)), 1'b0);
        check_draw(int'($urandom_range(127, 0)), int'($urandom_range(79, 0)), int'($urandom_range(59, 0)), 1'b0);
    endtask

    task automatic test_out_of_range;
        int cols [0:2];
        int rows [0:2];
        cols = '{80, int'($urandom_range(79, 0)), int'($urandom_range(127, 80))};
        rows = '{3, int'($urandom_range(63, 60)), int'($urandom_range(63, 0))};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 7'($urandom_range(127, 0)), 7'(cols[i]), 6'(rows[i]), 32'h0, 1'b0);
            cmd_valid = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                @(negedge CLK_25);
                checks++;
                if (WrEn !== 1'b0 || cmd_ready !== 1'b1 || err_range !== 1'b1) begin
                    failures++;
                    $display("FAIL oor_idle col=%0d row=%0d k=%0d: we=%b ready=%b err=%b required 0 1 1",
                             cols[i], rows[i], k, WrEn, cmd_ready, err_range);
                end
            end
        end
        check_draw(int'($urandom_range(127, 0)), 5, 7, 1'b0);
    endtask

    task automatic test_clear(input logic [31:0] fill);
        int n_we;
        int n_bad;
        issue(1'b1, 7'd0, 7'd0, 6'd0, fill, 1'b0);
        // A legal draw stays pending on the bus for the whole sweep.
        cmd_clear = 1'b0;
        cmd_col   = 7'd3;
        cmd_row   = 6'd3;
        n_we  = 0;
        n_bad = 0;
        for (int k = 1; k <= 9600; k++) begin
            @(negedge CLK_25);
            if (WrEn === 1'b1) n_we++;
            if (WrEn !== 1'b1 || WrAddress !== ADDR_W'(k - 1) || WrData !== fill || cmd_ready !== 1'b0)
                n_bad++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (n_we !== 9600) begin
            failures++;
            $display("FAIL clear_count: got %0d write cycles required 9600", n_we);
        end
        checks++;
        if (n_bad !== 0) begin
            failures++;
            $display("FAIL clear_sweep: got %0d bad cycles required 0", n_bad);
        end
        @(negedge CLK_25);
        checks++;
        if (cmd_ready !== 1'b1 || WrEn !== 1'b0) begin
            failures++;
            $display("FAIL clear_end: ready=%b we=%b required 1 0", cmd_ready, WrEn);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK_25);
            checks++;
            if (WrEn !== 1'b0) begin
                failures++;
                $display("FAIL clear_pending_ignored k=%0d: we=%b required 0", k, WrEn);
            end
        end
    endtask

    task automatic test_reset_mid_draw;
        int n_we;
        issue(1'b0, 7'($urandom_range(127, 0)), 7'd10, 6'd20, 32'h0, 1'b0);
        cmd_valid = 1'b0;
        repeat (6) @(negedge CLK_25);
        @(posedge CLK_25);
        #1 Reset = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, WrEn, WrData, WrAddress, font_addr, err_range} !==
            {1'b1, 1'b0, 32'd0, 14'd0, 10'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_draw: ready=%b we=%b data=%h addr=%0d fa=%h err=%b required 1 0 0 0 0 0",
                     cmd_ready, WrEn, WrData, WrAddress, font_addr, err_range);
        end
        @(negedge CLK_25);
        Reset = 1'b0;
        n_we = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK_25);
            if (WrEn === 1'b1) n_we++;
        end
        checks++;
        if (n_we !== 0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_no_bottom: writes=%0d ready=%b required 0 1", n_we, cmd_ready);
        end
    endtask

`ifdef FB_WR_INVERT_EN
    task automatic test_invert;
        check_draw(8'h48, 1, 0, 1'b1);
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
        test_reset;
        test_h_glyph;
        test_corners;
        test_random_draws;
        test_back_to_back;
        test_out_of_range;
        test_clear(32'hFFFFFFFF);
        test_clear($urandom);
        test_reset_mid_draw;
`ifdef FB_WR_INVERT_EN
        test_invert;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
